// File: rtl/cpu_trace_buffer.sv
// CPU trace FIFO: captures {PC, ALU result} per enabled cycle and pops them in order.
// Optional repeated-PC halt detection is compiled in with `define TRACE_HALT_DETECT_EN.
module cpu_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int HALT_CYCLES = 4
) (
  input  logic          ClkIn,
  input  logic          Rst,
  input  logic [31:0]   PCResult,
  input  logic [31:0]   ALUResult,
  input  logic          TraceEn,
  input  logic          RdEn,
  output logic          RdValid,
  output logic [31:0]   RdPC,
  output logic [31:0]   RdALU,
  output logic [AW:0]   Count,
  output logic          Empty,
  output logic          Full,
  output logic          Overflow,
  output logic          Halted
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_try;
  logic          do_pop;
  logic          do_wr;
  logic          drop;
  logic [AW:0]   count_nxt;

  // A full buffer still accepts a write when a pop frees a slot in the same cycle.
  always_comb begin
    wr_try    = TraceEn & ~Halted;
    do_pop    = RdEn & ~Empty;
    do_wr     = wr_try & (~Full | do_pop);
    drop      = wr_try & Full & ~do_pop;
    count_nxt = Count;
    if (do_wr && !do_pop)
      count_nxt = Count + 1'b1;
    else if (do_pop && !do_wr)
      count_nxt = Count - 1'b1;
  end

  always_ff @(posedge ClkIn) begin
    if (!Rst && do_wr)
      mem[wr_ptr] <= {PCResult, ALUResult};
  end

  always_ff @(posedge ClkIn) begin
    if (Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Empty    <= 1'b1;
      Full     <= 1'b0;
      Overflow <= 1'b0;
      RdValid  <= 1'b0;
      RdPC     <= '0;
      RdALU    <= '0;
    end else begin
      RdValid <= do_pop;
      if (do_pop) begin
        {RdPC, RdALU} <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop)
        Overflow <= 1'b1;
      Count <= count_nxt;
      Empty <= (count_nxt == '0);
      Full  <= (count_nxt == FULL_CNT);
    end
  end

`ifdef TRACE_HALT_DETECT_EN
  localparam logic [7:0] HALT_LAST = 8'(HALT_CYCLES - 1);

  logic [31:0] prev_pc;
  logic [7:0]  halt_cnt;

  // prev_pc follows the bus every cycle so the first post-reset compare is meaningful.
  always_ff @(posedge ClkIn) begin
    prev_pc <= PCResult;
    if (Rst) begin
      halt_cnt <= '0;
      Halted   <= 1'b0;
    end else if (TraceEn) begin
      if (PCResult == prev_pc) begin
        if (halt_cnt != HALT_LAST)
          halt_cnt <= halt_cnt + 8'd1;
        if (halt_cnt + 8'd1 == HALT_LAST)
          Halted <= 1'b1;
      end else begin
        halt_cnt <= '0;
      end
    end
  end
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed table, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_cpu_trace_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HALTN = 4;

  logic        ClkIn = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PCResult = '0;
  logic [31:0] ALUResult = '0;
  logic        TraceEn = 1'b0;
  logic        RdEn = 1'b0;
  logic        RdValid;
  logic [31:0] RdPC;
  logic [31:0] RdALU;
  logic [AW:0] Count;
  logic        Empty;
  logic        Full;
  logic        Overflow;
  logic        Halted;

  cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .HALT_CYCLES(HALTN)) dut (
    .ClkIn(ClkIn), .Rst(Rst), .PCResult(PCResult), .ALUResult(ALUResult),
    .TraceEn(TraceEn), .RdEn(RdEn), .RdValid(RdValid), .RdPC(RdPC), .RdALU(RdALU),
    .Count(Count), .Empty(Empty), .Full(Full), .Overflow(Overflow), .Halted(Halted)
  );

  always #5 ClkIn = ~ClkIn;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_alu = '0;
  logic [31:0] m_prev = '0;
  int          m_hcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic t, input logic d,
                            input logic [31:0] p, input logic [31:0] a);
    logic [63:0] e;
    bit pop, wr;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_halt = 0; m_hcnt = 0; m_valid = 0; m_pc = '0; m_alu = '0;
    end else begin
      pop = d && (mq.size() > 0);
      wr  = t && !m_halt;
      m_valid = pop;
      if (pop) begin
        e = mq.pop_front();
        m_pc = e[63:32];
        m_alu = e[31:0];
      end
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back({p, a});
        else m_ovf = 1;
      end
`ifdef TRACE_HALT_DETECT_EN
      if (t) begin
        if (p == m_prev) begin
          m_hcnt++;
          if (m_hcnt == HALTN - 1) m_halt = 1;
        end else begin
          m_hcnt = 0;
        end
      end
`endif
    end
    m_prev = p;
  endtask

  task automatic check_model();
    chk("count",    64'(Count),    64'(mq.size()));
    chk("empty",    64'(Empty),    64'(mq.size() == 0));
    chk("full",     64'(Full),     64'(mq.size() == DEPTH));
    chk("overflow", 64'(Overflow), 64'(m_ovf));
    chk("halted",   64'(Halted),   64'(m_halt));
    chk("rdvalid",  64'(RdValid),  64'(m_valid));
    chk("rddata",   {RdPC, RdALU}, {m_pc, m_alu});
  endtask

  task automatic apply(input logic r, input logic t, input logic d,
                       input logic [31:0] p, input logic [31:0] a);
    Rst = r; TraceEn = t; RdEn = d; PCResult = p; ALUResult = a;
    @(posedge ClkIn);
    model_step(r, t, d, p, a);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst, ten, rden;
    logic [31:0] pc, alu;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_alu;
  } vec_t;

  vec_t vecs[11];
  int   cnt_before;

  initial begin
    vecs[0]  = '{1, 0, 0, 32'h0,   32'h0,  0, 0, 32'h0, 32'h0};
    vecs[1]  = '{0, 1, 0, 32'h0,   32'h11, 1, 0, 32'h0, 32'h0};
    vecs[2]  = '{0, 1, 0, 32'h4,   32'h22, 2, 0, 32'h0, 32'h0};
    vecs[3]  = '{0, 1, 0, 32'h8,   32'h33, 3, 0, 32'h0, 32'h0};
    vecs[4]  = '{0, 0, 1, 32'h0,   32'h0,  2, 1, 32'h0, 32'h11};
    vecs[5]  = '{0, 0, 0, 32'h0,   32'h0,  2, 0, 32'h0, 32'h11};
    vecs[6]  = '{0, 0, 1, 32'h0,   32'h0,  1, 1, 32'h4, 32'h22};
    vecs[7]  = '{0, 0, 1, 32'h0,   32'h0,  0, 1, 32'h8, 32'h33};
    vecs[8]  = '{0, 0, 1, 32'h0,   32'h0,  0, 0, 32'h8, 32'h33};
    vecs[9]  = '{0, 1, 1, 32'h100, 32'h5,  1, 0, 32'h8, 32'h33};
    vecs[10] = '{1, 0, 0, 32'h0,   32'h0,  0, 0, 32'h0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].rst, vecs[i].ten, vecs[i].rden, vecs[i].pc, vecs[i].alu);
      chk($sformatf("vec%0d_count", i), 64'(Count), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(RdValid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_data", i), {RdPC, RdALU}, {vecs[i].exp_pc, vecs[i].exp_alu});
    end

    // 18 writes with no reads: fills, then drops two
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) apply(0, 1, 0, 32'(i * 4), 32'(i + 32'h1000));
    chk("fill_full", 64'(Full), 64'd1);
    chk("fill_count", 64'(Count), 64'd16);
    chk("fill_overflow", 64'(Overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      apply(0, 0, 1, 0, 0);
      chk($sformatf("fill_pop%0d_pc", i), 64'(RdPC), 64'(i * 4));
    end
    chk("fill_drained", 64'(Empty), 64'd1);

    // Simultaneous write and pop while full
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) apply(0, 1, 0, 32'(i * 4), 32'(i));
    apply(0, 1, 1, 32'h400, 32'hABCD);
    chk("wp_count", 64'(Count), 64'd16);
    chk("wp_overflow", 64'(Overflow), 64'd0);
    chk("wp_popped", 64'(RdPC), 64'h0);
    for (int i = 0; i < 16; i++) apply(0, 0, 1, 0, 0);
    chk("wp_newest", {RdPC, RdALU}, {32'h400, 32'hABCD});

    // Reset with entries stored
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 32'(32'h200 + i * 4), 32'(i));
    chk("pre_rst_count", 64'(Count), 64'd5);
    apply(1, 1, 1, 32'h300, 32'h1);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_empty", 64'(Empty), 64'd1);

    // Repeated PC: halts only with the detector compiled in
    apply(0, 1, 0, 32'h1C, 32'h7);
    cnt_before = int'(Count);
    for (int i = 0; i < 7; i++) apply(0, 1, 0, 32'h20, 32'(i));
`ifdef TRACE_HALT_DETECT_EN
    chk("halt_flag", 64'(Halted), 64'd1);
    chk("halt_count", 64'(Count), 64'(cnt_before + 4));
    apply(0, 0, 1, 0, 0);
    chk("halt_pop_ok", 64'(RdValid), 64'd1);
`else
    chk("halt_flag", 64'(Halted), 64'd0);
    chk("halt_count", 64'(Count), 64'(cnt_before + 7));
`endif

    // Random traffic in phases of varying read/write bias
    apply(1, 0, 0, 0, 0);
    for (int ph = 0; ph < 8; ph++) begin
      int wpct = 20 + 10 * ph;
      int rpct = 90 - 10 * ph;
      for (int c = 0; c < 250; c++) begin
        logic r, t, d;
        logic [31:0] p;
        r = ($urandom_range(0, 199) == 0);
        t = ($urandom_range(0, 99) < wpct);
        d = ($urandom_range(0, 99) < rpct);
        p = ($urandom_range(0, 9) < 3) ? PCResult : $urandom;
        apply(r, t, d, p, $urandom);
        if ($urandom_range(0, 99) == 0) apply(1, 0, 0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, sets the number of trace entries and SHALL be a power of two, 2 to 256.
REQ-002 Parameter AW, default 4, is the pointer width and SHALL equal log2(DEPTH).
REQ-003 Parameter HALT_CYCLES, default 4, is the number of repeated-PC cycles that declares a halt, range 2 to 255.
REQ-004 ClkIn  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Rst  in  1  reset, synchronous and active-high.
REQ-006 PCResult  in  32  CPU program counter, sampled every cycle.
REQ-007 ALUResult  in  32  CPU ALU result, sampled with PCResult.
REQ-008 TraceEn  in  1  capture enable.
REQ-009 RdEn  in  1  pop request from the trace reader.
REQ-010 RdValid  out  1  one-cycle pulse marking RdPC/RdALU as valid.
REQ-011 RdPC  out  32  popped PC.
REQ-012 RdALU  out  32  popped ALU result.
REQ-013 Count  out  AW+1  current number of stored entries.
REQ-014 Empty  out  1  Count==0.
REQ-015 Full  out  1  Count==DEPTH.
REQ-016 Overflow  out  1  sticky flag: a capture was dropped.
REQ-017 Halted  out  1  sticky halt-detect flag.

Function
REQ-018 A write SHALL occur in any cycle with TraceEn=1, Rst=0 and Halted=0. The write stores {PCResult, ALUResult} at the write pointer.
REQ-019 A write attempted while Full=1 and RdEn=0 SHALL be dropped, SHALL set Overflow, and SHALL leave the stored data unchanged.
REQ-020 A pop SHALL occur when RdEn=1 and Empty=0.
- RdPC/RdALU SHALL show the oldest entry one cycle after the pop (latency 1).
- RdValid SHALL be 1 in that same cycle only.
REQ-021 RdEn=1 while Empty=1 SHALL be ignored: no pop, RdValid=0, and RdPC/RdALU hold their values.
REQ-022 Write and pop in the same cycle:
- Count unchanged.
- When Full, the write SHALL be accepted and SHALL NOT set Overflow.
- When Empty, the pop is ignored and the write is accepted.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0. Count SHALL never exceed DEPTH and SHALL never go below 0.
REQ-024 Empty, Full and Count SHALL be registered and consistent with each other in every cycle.
REQ-025 RdPC/RdALU SHALL hold their last popped values between pops.

Reset
REQ-026 When Rst=1 at a clock edge:
- Count=0, Empty=1, Full=0, Overflow=0, Halted=0, RdValid=0, RdPC=0, RdALU=0.
- Both pointers=0 and the halt counter=0.
REQ-027 Rst SHALL take priority over any simultaneous write or pop. A reset mid-operation SHALL discard all stored entries; the storage array itself need not be cleared.

Configuration
REQ-028 Macro TRACE_HALT_DETECT_EN SHALL compile halt detection in or out.
REQ-029 With TRACE_HALT_DETECT_EN defined:
- A counter SHALL increment each TraceEn=1 cycle in which PCResult equals the previous cycle's PCResult, and SHALL clear when they differ.
- When the counter reaches HALT_CYCLES-1, Halted SHALL be set (sticky) on that edge.
- No writes SHALL occur from the following cycle onward.
- Pops SHALL continue normally.
REQ-030 Without TRACE_HALT_DETECT_EN, Halted SHALL be constant 0, no compare logic SHALL be present, and capture SHALL depend only on TraceEn.

Verification
REQ-031 Reset, then TraceEn=1 for 3 cycles with PC=0x0,0x4,0x8 and ALU=0x11,0x22,0x33 -> Count=3; three RdEn pulses return (0x0,0x11), (0x4,0x22), (0x8,0x33), each with RdValid one cycle after RdEn.
REQ-032 TraceEn=1 for 18 cycles with incrementing PC, no reads -> Full=1 at Count=16, Overflow=1, and popped entries are PC 0x00..0x3C.
REQ-033 With Full=1, RdEn=1 and TraceEn=1 in the same cycle -> Count stays 16, Overflow stays 0, and the newest PC is stored.
REQ-034 RdEn=1 while Empty -> RdValid=0, Count=0, outputs unchanged. Rst=1 asserted with Count=5 -> Count=0 and Empty=1 after the edge.
REQ-035 With TRACE_HALT_DETECT_EN defined, PC=0x20 is held for 4 cycles -> Halted=1 and Count grows by at most 4 then freezes. Without the macro, the same stimulus -> Halted=0 and Count keeps incrementing.
